// File: rtl/ntsc_pattern_pkg.sv
// rtl/ntsc_pattern_pkg.sv - mode encodings, component helpers and colour-bar table
package ntsc_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_SOLID = 2'd3
  } pattern_mode_e;

  function automatic int unsigned comp_mid(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic int unsigned comp_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // 100% bars as 8-bit {Y,Cr,Cb}; narrower components take the top bits
  function automatic logic [23:0] bar_ycrcb8(input logic [2:0] idx);
    case (idx)
      3'd0:    return {8'd235, 8'd128, 8'd128};
      3'd1:    return {8'd210, 8'd146, 8'd16};
      3'd2:    return {8'd170, 8'd16,  8'd166};
      3'd3:    return {8'd145, 8'd34,  8'd54};
      3'd4:    return {8'd106, 8'd222, 8'd202};
      3'd5:    return {8'd81,  8'd240, 8'd90};
      3'd6:    return {8'd41,  8'd110, 8'd240};
      default: return {8'd16,  8'd128, 8'd128};
    endcase
  endfunction

endpackage

// File: rtl/ntsc_pattern_pixel.sv
// rtl/ntsc_pattern_pixel.sv - combinational pattern colour for one pixel position
module ntsc_pattern_pixel
  import ntsc_pattern_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int COMP_W     = 6,
  parameter int CHECK_LOG2 = 5
) (
  input  logic [1:0]          mode,
  input  logic [9:0]          xp,
  input  logic [8:0]          y,
  input  logic [3*COMP_W-1:0] solid_ycrcb,
  output logic [3*COMP_W-1:0] ycrcb
);

  localparam logic [COMP_W-1:0] MID = COMP_W'(comp_mid(COMP_W));
  localparam logic [COMP_W-1:0] MAX = COMP_W'(comp_max(COMP_W));

  logic [12:0]       xp_x8;
  logic [2:0]        bar_idx;
  logic [23:0]       bar8;
  logic [COMP_W-1:0] ramp_y;
  logic              check_on;

  // 13 bits holds 8*xp for any 10-bit x without overflow
  assign xp_x8    = {xp, 3'b000};
  assign bar_idx  = 3'(xp_x8 / 13'(H_ACTIVE));
  assign bar8     = bar_ycrcb8(bar_idx);
  assign ramp_y   = COMP_W'({1'b0, xp} + {2'b00, y});
  assign check_on = 1'((xp >> CHECK_LOG2) ^ ({1'b0, y} >> CHECK_LOG2));

  always_comb begin
    ycrcb = '0;
    case (mode)
      MODE_RAMP:  ycrcb = {ramp_y, MID, MID};
      MODE_BARS:  ycrcb = {COMP_W'(bar8[23:16] >> (8 - COMP_W)),
                           COMP_W'(bar8[15:8]  >> (8 - COMP_W)),
                           COMP_W'(bar8[7:0]   >> (8 - COMP_W))};
      MODE_CHECK: ycrcb = check_on ? {MAX, MID, MID} : {{COMP_W{1'b0}}, MID, MID};
      default:    ycrcb = solid_ycrcb;
    endcase
  end

endmodule

// File: rtl/ntsc_pattern_gen.sv
// rtl/ntsc_pattern_gen.sv - synthetic raster source with word-rate divider and valid/ready output
module ntsc_pattern_gen
  import ntsc_pattern_pkg::*;
#(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int COMP_W       = 6,
  parameter int PIX_PER_WORD = 2,
  parameter int RATE_DIV     = 4,
  parameter int CHECK_LOG2   = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [1:0]                       mode,
  input  logic [3*COMP_W-1:0]              solid_ycrcb,
  input  logic                             ntsc_ready,
  output logic [PIX_PER_WORD*3*COMP_W-1:0] ntsc_pixels,
  output logic                             ntsc_flag,
  output logic                             frame_flag,
  output logic                             line_flag,
  output logic [9:0]                       x_out,
  output logic [8:0]                       y_out
);

  localparam int                PXW      = 3 * COMP_W;
  localparam int                DIV_W    = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RATE_DIV - 1);
  localparam logic [9:0]        X_LAST   = 10'(H_ACTIVE - PIX_PER_WORD);
  localparam logic [9:0]        X_STEP   = 10'(PIX_PER_WORD);
  localparam logic [8:0]        Y_LAST   = 9'(V_ACTIVE - 1);

  logic [DIV_W-1:0]                 div_cnt;
  logic [9:0]                       x_cnt;
  logic [8:0]                       y_cnt;
  logic [1:0]                       mode_q;
  logic [PXW-1:0]                   colour_q;
  logic                             tick;
  logic                             load;
  logic                             frame_start;
  logic [1:0]                       mode_eff;
  logic [PXW-1:0]                   colour_eff;
  logic [PIX_PER_WORD*PXW-1:0]      word_next;

  assign tick        = enable && (div_cnt == DIV_LAST);
  assign load        = tick && (!ntsc_flag || ntsc_ready);
  assign frame_start = (x_cnt == 10'd0) && (y_cnt == 9'd0);
  // The word that opens a frame sees the live inputs; the rest of the frame uses the latched copy
  assign mode_eff    = frame_start ? mode : mode_q;
  assign colour_eff  = frame_start ? solid_ycrcb : colour_q;

  for (genvar i = 0; i < PIX_PER_WORD; i++) begin : g_pix
    ntsc_pattern_pixel #(
      .H_ACTIVE   (H_ACTIVE),
      .COMP_W     (COMP_W),
      .CHECK_LOG2 (CHECK_LOG2)
    ) u_pixel (
      .mode        (mode_eff),
      .xp          (x_cnt + 10'(i)),
      .y           (y_cnt),
      .solid_ycrcb (colour_eff),
      .ycrcb       (word_next[(PIX_PER_WORD-1-i)*PXW +: PXW])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      mode_q      <= MODE_RAMP;
      colour_q    <= '0;
      ntsc_pixels <= '0;
      ntsc_flag   <= 1'b0;
      frame_flag  <= 1'b0;
      line_flag   <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
    end else begin
      if (enable) begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      end
      // A tick that arrives while the consumer stalls is simply lost
      if (load) begin
        ntsc_pixels <= word_next;
        ntsc_flag   <= 1'b1;
        frame_flag  <= frame_start;
        line_flag   <= (x_cnt == 10'd0);
        x_out       <= x_cnt;
        y_out       <= y_cnt;
        if (frame_start) begin
          mode_q   <= mode;
          colour_q <= solid_ycrcb;
        end
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == Y_LAST) ? 9'd0 : y_cnt + 9'd1;
        end else begin
          x_cnt <= x_cnt + X_STEP;
        end
      end else if (ntsc_flag && ntsc_ready) begin
        ntsc_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ntsc_pattern_gen.sv
// tb/tb_ntsc_pattern_gen.sv - directed checks of pattern, raster, handshake and reset behaviour
module tb_ntsc_pattern_gen;

  localparam int A_H = 640;
  localparam int A_V = 4;
  localparam int A_DIV = 4;
  localparam int B_H = 64;
  localparam int B_V = 480;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, en_a, ready_a;
  logic [1:0]  mode_a;
  logic [17:0] solid_a;
  logic [35:0] pix_a;
  logic        flag_a, ff_a, lf_a;
  logic [9:0]  x_a;
  logic [8:0]  y_a;

  logic        rst_b, en_b, ready_b;
  logic [1:0]  mode_b;
  logic [17:0] solid_b;
  logic [35:0] pix_b;
  logic        flag_b, ff_b, lf_b;
  logic [9:0]  x_b;
  logic [8:0]  y_b;

  int n_checks;
  int n_fail;

  ntsc_pattern_gen #(
    .H_ACTIVE(A_H), .V_ACTIVE(A_V), .COMP_W(6), .PIX_PER_WORD(2), .RATE_DIV(A_DIV), .CHECK_LOG2(5)
  ) dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .mode(mode_a), .solid_ycrcb(solid_a),
    .ntsc_ready(ready_a), .ntsc_pixels(pix_a), .ntsc_flag(flag_a), .frame_flag(ff_a),
    .line_flag(lf_a), .x_out(x_a), .y_out(y_a)
  );

  ntsc_pattern_gen #(
    .H_ACTIVE(B_H), .V_ACTIVE(B_V), .COMP_W(6), .PIX_PER_WORD(2), .RATE_DIV(1), .CHECK_LOG2(5)
  ) dut_b (
    .clk(clk), .reset(rst_b), .enable(en_b), .mode(mode_b), .solid_ycrcb(solid_b),
    .ntsc_ready(ready_b), .ntsc_pixels(pix_b), .ntsc_flag(flag_b), .frame_flag(ff_b),
    .line_flag(lf_b), .x_out(x_b), .y_out(y_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] w2(input logic [5:0] y0, cr0, cb0, y1, cr1, cb1);
    return {y0, cr0, cb0, y1, cr1, cb1};
  endfunction

  task automatic seek_a(input logic [9:0] tx, input logic [8:0] ty);
    int c = 0;
    @(negedge clk);
    while (!(flag_a && x_a == tx && y_a == ty) && c < 6000) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    int n, acc, cyc, unstable, gaps, lf_bad;
    bit bp_done, sw_done;
    logic [35:0] hold_pix;
    logic [9:0]  hold_x, prev_x;
    logic [8:0]  prev_y;

    n_checks = 0;
    n_fail   = 0;
    rst_a = 1'b1; en_a = 1'b0; ready_a = 1'b1; mode_a = 2'd0; solid_a = 18'h0;
    rst_b = 1'b1; en_b = 1'b0; ready_b = 1'b1; mode_b = 2'd2; solid_b = 18'h3F820;
    repeat (3) @(negedge clk);

    check_eq("a_rst_flag", 64'(flag_a), 64'd0);
    check_eq("a_rst_pix", 64'(pix_a), 64'd0);
    check_eq("a_rst_xyff", 64'({x_a, y_a, ff_a, lf_a}), 64'd0);
    check_eq("b_rst_flag", 64'(flag_b), 64'd0);

    // ---------- instance A: defaults except a 4-line frame ----------
    rst_a = 1'b0;
    en_a  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!flag_a && n < 20);
    check_eq("a_latency", 64'(n), 64'(A_DIV));
    check_eq("a_first_ff_lf", 64'({ff_a, lf_a}), 64'b11);
    check_eq("a_first_xy", 64'({x_a, y_a}), 64'd0);
    check_eq("a_first_pix", 64'(pix_a), 64'(w2(0, 32, 32, 1, 32, 32)));

    acc = 0; cyc = 0; bp_done = 0; sw_done = 0;
    while (cyc < 8000) begin
      if (flag_a && ready_a) begin
        if (ff_a && acc > 0) break;
        if (!bp_done && x_a == 10'd100 && y_a == 9'd0) begin
          ready_a = 1'b0;
          hold_pix = pix_a; hold_x = x_a; unstable = 0;
          repeat (10) begin
            @(negedge clk); cyc++;
            if (!flag_a || pix_a != hold_pix || x_a != hold_x) unstable++;
          end
          check_eq("a_bp_stable", 64'(unstable), 64'd0);
          ready_a = 1'b1;
          bp_done = 1'b1;
          acc++;
          n = 0;
          do begin @(negedge clk); cyc++; n++; end while (!flag_a && n < 20);
          check_eq("a_bp_gap", 64'(n), 64'd2);
          check_eq("a_bp_next_x", 64'(x_a), 64'd102);
          continue;
        end
        if (!sw_done && y_a == 9'd2) begin
          mode_a  = 2'd1;
          sw_done = 1'b1;
        end
        if (y_a == 9'd3 && x_a == 10'd0)
          check_eq("a_ramp_after_switch", 64'(pix_a), 64'(w2(3, 32, 32, 4, 32, 32)));
        acc++;
      end
      @(negedge clk); cyc++;
    end
    check_eq("a_frame_words", 64'(acc), 64'(A_H / 2 * A_V));
    check_eq("a_f2_xy_ff", 64'({x_a, y_a, ff_a}), 64'd1);
    check_eq("a_f2_white", 64'(pix_a), 64'(w2(58, 32, 32, 58, 32, 32)));

    seek_a(10'd80, 9'd0);
    check_eq("a_f2_x80", 64'(x_a), 64'd80);
    check_eq("a_f2_yellow", 64'(pix_a), 64'(w2(52, 36, 4, 52, 36, 4)));

    // pause with a word pending: it still completes, then nothing until re-enabled
    en_a = 1'b0;
    n = 0;
    repeat (20) begin @(negedge clk); if (flag_a) n++; end
    check_eq("a_pause_idle", 64'(n), 64'd0);
    en_a = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!flag_a && n < 20);
    check_eq("a_resume_x", 64'({x_a, y_a}), 64'({10'd82, 9'd0}));

    seek_a(10'd0, 9'd3);
    check_eq("a_pre_rst_flag", 64'(flag_a), 64'd1);
    rst_a = 1'b1;
    #1;
    check_eq("a_async_rst_flag", 64'(flag_a), 64'd0);
    check_eq("a_async_rst_out", 64'({pix_a, x_a, y_a, ff_a, lf_a}), 64'd0);
    mode_a = 2'd0;
    @(negedge clk);
    rst_a = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!flag_a && n < 20);
    check_eq("a_restart_latency", 64'(n), 64'(A_DIV));
    check_eq("a_restart_xy_ff", 64'({x_a, y_a, ff_a}), 64'd1);
    check_eq("a_restart_pix", 64'(pix_a), 64'(w2(0, 32, 32, 1, 32, 32)));

    // ---------- instance B: RATE_DIV=1, 64x480, checkerboard then solid ----------
    en_b = 1'b1;
    rst_b = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!flag_b && n < 20);
    check_eq("b_latency", 64'(n), 64'd1);
    check_eq("b_first_ff", 64'(ff_b), 64'd1);

    acc = 0; cyc = 0; gaps = 0; lf_bad = 0; prev_x = '0; prev_y = '0;
    while (cyc < 17000) begin
      if (!flag_b) gaps++;
      else begin
        if (ff_b && acc > 0) break;
        if (lf_b != (x_b == 10'd0)) lf_bad++;
        if (x_b == 10'd30 && y_b == 9'd0) check_eq("b_chk_31_0", 64'(pix_b[17:12]), 64'd0);
        if (x_b == 10'd32 && y_b == 9'd0) check_eq("b_chk_32_0", 64'(pix_b[35:30]), 64'd63);
        if (x_b == 10'd32 && y_b == 9'd32) check_eq("b_chk_32_32", 64'(pix_b[35:30]), 64'd0);
        if (x_b == 10'd32 && y_b == 9'd200) mode_b = 2'd3;
        if (x_b == 10'd32 && y_b == 9'd201) check_eq("b_mode_held", 64'(pix_b[35:30]), 64'd63);
        prev_x = x_b;
        prev_y = y_b;
        acc++;
      end
      @(negedge clk); cyc++;
    end
    check_eq("b_no_gaps", 64'(gaps), 64'd0);
    check_eq("b_line_flag", 64'(lf_bad), 64'd0);
    check_eq("b_frame_words", 64'(acc), 64'(B_H / 2 * B_V));
    check_eq("b_wrap_prev", 64'({prev_y, prev_x}), 64'({9'd479, 10'd62}));
    check_eq("b_wrap_xy_ff_lf", 64'({x_b, y_b, ff_b, lf_b}), 64'b11);
    check_eq("b_solid_first", 64'(pix_b), 64'({18'h3F820, 18'h3F820}));
    repeat (45) @(negedge clk);
    check_eq("b_solid_xy", 64'({x_b, y_b}), 64'({10'd26, 9'd1}));
    check_eq("b_solid_later", 64'(pix_b), 64'({18'h3F820, 18'h3F820}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
